// File: rtl/instruction_set_pkg.sv
// Shared z8 definitions: word size, I/O window base and the I/O register offset map.
package instruction_set;
    localparam int WORD_SIZE = 8;
    localparam logic [7:0] IO_BASE_DEFAULT = 8'hF0;
    localparam int BANK1_BITS = 6;

    typedef enum logic [3:0] {
        IO_BANK0_0 = 4'h0,
        IO_BANK0_1 = 4'h1,
        IO_BANK0_2 = 4'h2,
        IO_BANK1_0 = 4'h3,
        IO_BANK1_1 = 4'h4,
        IO_BANK1_2 = 4'h5,
        IO_BANK1_3 = 4'h6,
        IO_CTRL    = 4'h7,
        IO_SW_LO   = 4'h8,
        IO_SW_HI   = 4'h9,
        IO_KEYS    = 4'hA
    } io_reg_e;
endpackage

// File: rtl/io_register_file_key_debouncer.sv
// One push button: invert, 2-flop synchronise, then accept a new level only after
// it has been stable for DEBOUNCE_CYCLES synchronised cycles.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_n,
    output logic level,
    output logic rise
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta_reg;
    logic          sync_reg;
    logic [CW-1:0] cnt_reg;
    logic          done;

    assign done = (cnt_reg == CNT_MAX);
    // High in the cycle whose closing edge raises level, so the flag sets on that same edge.
    assign rise = done & sync_reg & ~level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
            cnt_reg  <= '0;
            level    <= 1'b0;
        end else begin
            meta_reg <= ~raw_n;
            sync_reg <= meta_reg;
            // Counting only while a change is pending; a glitch back to level restarts it.
            if (sync_reg == level) begin
                cnt_reg <= '0;
            end else if (done) begin
                level   <= sync_reg;
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end
endmodule

// File: rtl/io_register_file.sv
// Memory-mapped I/O window for the z8 core: display banks, bank select, synchronised
// switches and debounced keys with sticky press flags. Reads return one cycle later.
module io_register_file
    import instruction_set::*;
#(
    parameter logic [7:0] IO_BASE         = IO_BASE_DEFAULT,
    parameter int         DEBOUNCE_CYCLES = 250000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic                      rd_en,
    input  logic [7:0]                addr,
    input  logic [WORD_SIZE-1:0]      wr_data,
    output logic [WORD_SIZE-1:0]      rd_data,
    output logic                      rd_valid,
    input  logic [9:0]                sw_in,
    input  logic [1:0]                key_in,
    output logic [2:0][WORD_SIZE-1:0] bank_0_out,
    output logic [3:0][WORD_SIZE-1:0] bank_1_out,
    output logic                      bank_sel
);
    logic                  hit;
    logic [3:0]            off;
    logic                  wr_hit;
    logic [WORD_SIZE-1:0]  rd_mux;
    logic                  key_clear;

    logic [WORD_SIZE-1:0]  bank0_reg [3];
    logic [BANK1_BITS-1:0] bank1_reg [4];
    logic                  bank_sel_reg;
    logic [9:0]            sw_meta_reg;
    logic [9:0]            sw_sync_reg;
    logic [1:0]            key_level;
    logic [1:0]            key_rise;
    logic [1:0]            flag_reg;

    assign hit       = (addr[7:4] == IO_BASE[7:4]);
    assign off       = addr[3:0];
    assign wr_hit    = wr_en & hit;
    assign key_clear = rd_en & hit & (off == IO_KEYS);
    assign bank_sel  = bank_sel_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_bank0
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    bank0_reg[gi] <= '0;
                end else if (wr_hit && off == 4'(gi)) begin
                    bank0_reg[gi] <= wr_data;
                end
            end
            assign bank_0_out[gi] = bank0_reg[gi];
        end

        for (gi = 0; gi < 4; gi++) begin : g_bank1
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    bank1_reg[gi] <= '0;
                end else if (wr_hit && off == 4'(gi + 3)) begin
                    bank1_reg[gi] <= wr_data[BANK1_BITS-1:0];
                end
            end
            assign bank_1_out[gi] = {{(WORD_SIZE-BANK1_BITS){1'b0}}, bank1_reg[gi]};
        end

        for (gi = 0; gi < 2; gi++) begin : g_key
            key_debouncer #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_key (
                .clk  (clk),
                .rst_n(rst_n),
                .raw_n(key_in[gi]),
                .level(key_level[gi]),
                .rise (key_rise[gi])
            );
        end
    endgenerate

    always_comb begin
        rd_mux = '0;
        if (hit) begin
            case (io_reg_e'(off))
                IO_BANK0_0: rd_mux = bank0_reg[0];
                IO_BANK0_1: rd_mux = bank0_reg[1];
                IO_BANK0_2: rd_mux = bank0_reg[2];
                IO_BANK1_0: rd_mux[BANK1_BITS-1:0] = bank1_reg[0];
                IO_BANK1_1: rd_mux[BANK1_BITS-1:0] = bank1_reg[1];
                IO_BANK1_2: rd_mux[BANK1_BITS-1:0] = bank1_reg[2];
                IO_BANK1_3: rd_mux[BANK1_BITS-1:0] = bank1_reg[3];
                IO_CTRL:    rd_mux[0] = bank_sel_reg;
                IO_SW_LO:   rd_mux = sw_sync_reg[7:0];
                IO_SW_HI:   rd_mux[1:0] = sw_sync_reg[9:8];
                IO_KEYS:    rd_mux[3:0] = {flag_reg, key_level};
                default:    rd_mux = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_sel_reg <= 1'b0;
            sw_meta_reg  <= '0;
            sw_sync_reg  <= '0;
            flag_reg     <= '0;
            rd_data      <= '0;
            rd_valid     <= 1'b0;
        end else begin
            if (wr_hit && off == IO_CTRL) begin
                bank_sel_reg <= wr_data[0];
            end
            sw_meta_reg <= sw_in;
            sw_sync_reg <= sw_meta_reg;
            // A press arriving on the clearing read's edge still leaves its flag set.
            flag_reg <= (flag_reg & ~{2{key_clear}}) | key_rise;
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_mux;
            end
        end
    end
endmodule

// File: tb/tb_io_register_file.sv
// Directed checks of io_register_file with a short debounce window.
module tb_io_register_file;
    logic            clk;
    logic            rst_n;
    logic            wr_en;
    logic            rd_en;
    logic [7:0]      addr;
    logic [7:0]      wr_data;
    logic [7:0]      rd_data;
    logic            rd_valid;
    logic [9:0]      sw_in;
    logic [1:0]      key_in;
    logic [2:0][7:0] bank_0_out;
    logic [3:0][7:0] bank_1_out;
    logic            bank_sel;

    int n_checks;
    int n_fail;

    io_register_file #(
        .IO_BASE        (8'hF0),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .addr      (addr),
        .wr_data   (wr_data),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .sw_in     (sw_in),
        .key_in    (key_in),
        .bank_0_out(bank_0_out),
        .bank_1_out(bank_1_out),
        .bank_sel  (bank_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    // Drivers: stimulus changes 1 ns after a rising edge, results sampled 1 ns after the next.
    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        wr_en = 1'b1; addr = a; wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] a, output logic [7:0] d, output logic v);
        rd_en = 1'b1; addr = a;
        @(posedge clk); #1;
        rd_en = 1'b0;
        d = rd_data; v = rd_valid;
    endtask

    task automatic test_reset;
        do_write(8'hF0, 8'h5A);
        do_write(8'hF3, 8'h2A);
        do_write(8'hF7, 8'h01);
        rd_en = 1'b1; addr = 8'hF0;
        @(posedge clk); #2;
        rd_en = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bank_0_out !== '0 || bank_1_out !== '0) begin
            n_fail++;
            $display("FAIL reset_banks: bank_0_out=%h bank_1_out=%h, required 0", bank_0_out, bank_1_out);
        end
        n_checks++;
        if (bank_sel !== 1'b0 || rd_data !== 8'h00 || rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: bank_sel=%b rd_data=%h rd_valid=%b, required 0/00/0",
                     bank_sel, rd_data, rd_valid);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read;
        logic [7:0] d;
        logic       v;
        do_write(8'hF1, 8'hA5);
        n_checks++;
        if (bank_0_out[1] !== 8'hA5) begin
            n_fail++;
            $display("FAIL write_bank0: bank_0_out[1]=%h, required a5", bank_0_out[1]);
        end
        do_write(8'hF4, 8'hFF);
        n_checks++;
        if (bank_1_out[1] !== 8'h3F) begin
            n_fail++;
            $display("FAIL write_bank1: bank_1_out[1]=%h, required 3f", bank_1_out[1]);
        end
        do_write(8'hF7, 8'h01);
        n_checks++;
        if (bank_sel !== 1'b1) begin
            n_fail++;
            $display("FAIL write_ctrl: bank_sel=%b, required 1", bank_sel);
        end
        do_write(8'hF8, 8'h77);
        do_write(8'hE1, 8'h66);
        n_checks++;
        if (bank_0_out[1] !== 8'hA5) begin
            n_fail++;
            $display("FAIL write_miss: bank_0_out[1]=%h, required a5", bank_0_out[1]);
        end
        do_read(8'hF4, d, v);
        n_checks++;
        if (d !== 8'h3F || v !== 1'b1) begin
            n_fail++;
            $display("FAIL read_bank1: rd_data=%h rd_valid=%b, required 3f/1", d, v);
        end
        do_read(8'hF7, d, v);
        n_checks++;
        if (d !== 8'h01) begin
            n_fail++;
            $display("FAIL read_ctrl: rd_data=%h, required 01", d);
        end
        @(posedge clk); #1;
        n_checks++;
        if (rd_valid !== 1'b0 || rd_data !== 8'h01) begin
            n_fail++;
            $display("FAIL read_hold: rd_valid=%b rd_data=%h, required 0/01", rd_valid, rd_data);
        end
    endtask

    task automatic test_back_to_back;
        rd_en = 1'b1; addr = 8'hF1;
        @(posedge clk); #1;
        n_checks++;
        if (rd_data !== 8'hA5 || rd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first: rd_data=%h rd_valid=%b, required a5/1", rd_data, rd_valid);
        end
        addr = 8'hF4;
        @(posedge clk); #1;
        rd_en = 1'b0;
        n_checks++;
        if (rd_data !== 8'h3F || rd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second: rd_data=%h rd_valid=%b, required 3f/1", rd_data, rd_valid);
        end
    endtask

    task automatic test_switches;
        logic [7:0] d;
        logic       v;
        sw_in = 10'h2C3;
        repeat (2) @(posedge clk);
        #1;
        do_read(8'hF8, d, v);
        n_checks++;
        if (d !== 8'hC3 || v !== 1'b1) begin
            n_fail++;
            $display("FAIL sw_lo: rd_data=%h rd_valid=%b, required c3/1", d, v);
        end
        do_read(8'hF9, d, v);
        n_checks++;
        if (d !== 8'h02) begin
            n_fail++;
            $display("FAIL sw_hi: rd_data=%h, required 02", d);
        end
        do_read(8'hFC, d, v);
        n_checks++;
        if (d !== 8'h00 || v !== 1'b1) begin
            n_fail++;
            $display("FAIL reserved_read: rd_data=%h rd_valid=%b, required 00/1", d, v);
        end
        do_read(8'h10, d, v);
        n_checks++;
        if (d !== 8'h00 || v !== 1'b1) begin
            n_fail++;
            $display("FAIL miss_read: rd_data=%h rd_valid=%b, required 00/1", d, v);
        end
    endtask

    task automatic test_debounce;
        logic [7:0] d;
        logic       v;
        key_in[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1 key_in[0] = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        do_read(8'hFA, d, v);
        n_checks++;
        if (d !== 8'h00) begin
            n_fail++;
            $display("FAIL key_glitch: rd_data=%h, required 00", d);
        end
        key_in[0] = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        do_read(8'hFA, d, v);
        n_checks++;
        if (d !== 8'h05) begin
            n_fail++;
            $display("FAIL key_press: rd_data=%h, required 05", d);
        end
        do_read(8'hFA, d, v);
        n_checks++;
        if (d !== 8'h01) begin
            n_fail++;
            $display("FAIL key_flag_clear: rd_data=%h, required 01", d);
        end
        key_in[0] = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        do_read(8'hFA, d, v);
        n_checks++;
        if (d !== 8'h00) begin
            n_fail++;
            $display("FAIL key_release: rd_data=%h, required 00", d);
        end
    endtask

    task automatic test_clear_race;
        logic [7:0] d;
        logic       v;
        // Level rises on the 6th edge after the press; the read is accepted on that edge.
        key_in[1] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        do_read(8'hFA, d, v);
        n_checks++;
        if (d !== 8'h00) begin
            n_fail++;
            $display("FAIL race_read: rd_data=%h, required 00", d);
        end
        do_read(8'hFA, d, v);
        n_checks++;
        if (d !== 8'h0A) begin
            n_fail++;
            $display("FAIL race_flag_kept: rd_data=%h, required 0a", d);
        end
        key_in[1] = 1'b1;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic test_rw_same_cycle;
        logic [7:0] d;
        logic       v;
        do_write(8'hF0, 8'h11);
        wr_en = 1'b1; rd_en = 1'b1; addr = 8'hF0; wr_data = 8'h22;
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
        n_checks++;
        if (rd_data !== 8'h11 || bank_0_out[0] !== 8'h22) begin
            n_fail++;
            $display("FAIL rw_same: rd_data=%h bank_0_out[0]=%h, required 11/22", rd_data, bank_0_out[0]);
        end
        do_read(8'hF0, d, v);
        n_checks++;
        if (d !== 8'h22) begin
            n_fail++;
            $display("FAIL rw_after: rd_data=%h, required 22", d);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        addr     = 8'h00;
        wr_data  = 8'h00;
        sw_in    = 10'h000;
        key_in   = 2'b11;
        #2;
        n_checks++;
        if (bank_0_out !== '0 || bank_1_out !== '0 || bank_sel !== 1'b0 || rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL initial_reset: banks=%h/%h bank_sel=%b rd_valid=%b, required all 0",
                     bank_0_out, bank_1_out, bank_sel, rd_valid);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        test_reset();
        test_write_read();
        test_back_to_back();
        test_switches();
        test_debounce();
        test_clear_race();
        test_rw_same_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
